// File: rtl/nway_plru_cru.sv
// nway_plru_cru: N-way tree pseudo-LRU replacement unit for set-associative caches.
// Keeps a heap-ordered PLRU tree and a valid vector for every set, nominates a
// victim (an invalid way if there is one, otherwise the tree victim), and walks
// every set clearing its state when a flush is requested.
// Optional build macro: CRU_STATS_EN adds saturating hit/replace counters.
module nway_plru_cru #(
   parameter int ADDR_SIZE  = 32,
   parameter int NUM_SETS   = 16,
   parameter int BLOCK_SIZE = 32,
   parameter int NUM_WAYS   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ADDR_SIZE-1:0]          addr,
   input  logic                          access,
   input  logic [$clog2(NUM_WAYS)-1:0]   hit_way,
   input  logic                          replace,
   input  logic                          invalidate,
   input  logic [$clog2(NUM_WAYS)-1:0]   inv_way,
   input  logic                          flush,
   output logic [$clog2(NUM_WAYS)-1:0]   preferred,
`ifdef CRU_STATS_EN
   output logic [31:0]                   hit_count,
   output logic [31:0]                   replace_count,
`endif
   output logic                          busy
);

   localparam int OFF_W  = $clog2(BLOCK_SIZE / 4);
   localparam int SET_W  = $clog2(NUM_SETS);
   localparam int WAY_W  = $clog2(NUM_WAYS);
   localparam int TREE_W = NUM_WAYS - 1;

   typedef enum logic {
      ST_IDLE,
      ST_FLUSH
   } state_t;

   state_t                 state;
   state_t                 next_state;
   logic [SET_W-1:0]       counter;
   logic [SET_W-1:0]       next_counter;

   logic [TREE_W-1:0]      tree_q  [NUM_SETS];
   logic [NUM_WAYS-1:0]    valid_q [NUM_SETS];

   logic [SET_W-1:0]       set_idx;
   logic [TREE_W-1:0]      cur_tree;
   logic [NUM_WAYS-1:0]    cur_valid;
   logic [WAY_W-1:0]       victim;
   logic                   idle;
   logic                   flush_accept;
   logic                   do_replace;
   logic                   do_access;
   logic                   do_invalidate;
   logic                   unused_addr;

   // Touch: every node on the root-to-leaf path of way w is pointed away from w.
   // A node at level lvl, position pos covers ways [pos*span, (pos+1)*span).
   function automatic logic [TREE_W-1:0] tree_touch(input logic [TREE_W-1:0] t,
                                                    input logic [WAY_W-1:0]  w);
      logic [TREE_W-1:0] r;
      logic              away;
      int                span;
      int                node;
      r = t;
      for (int lvl = 0; lvl < WAY_W; lvl++) begin
         span = NUM_WAYS >> lvl;
         for (int pos = 0; pos < (1 << lvl); pos++) begin
            node = (1 << lvl) - 1 + pos;
            if ((int'(w) / span) == pos) begin
               away = ((int'(w) % span) < (span / 2));
               r = (r & ~(TREE_W'(1) << node)) | (TREE_W'(away) << node);
            end
         end
      end
      return r;
   endfunction

   // Tree victim: the unique way whose whole path has every node pointing at it.
   function automatic logic [WAY_W-1:0] tree_victim(input logic [TREE_W-1:0] t);
      logic [WAY_W-1:0]  r;
      logic [TREE_W-1:0] shifted;
      logic              match;
      logic              upper;
      int                span;
      int                node;
      r = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         match = 1'b1;
         for (int lvl = 0; lvl < WAY_W; lvl++) begin
            span = NUM_WAYS >> lvl;
            for (int pos = 0; pos < (1 << lvl); pos++) begin
               node = (1 << lvl) - 1 + pos;
               if ((w / span) == pos) begin
                  shifted = t >> node;
                  upper   = ((w % span) >= (span / 2));
                  if (shifted[0] != upper) begin
                     match = 1'b0;
                  end
               end
            end
         end
         if (match) begin
            r = WAY_W'(w);
         end
      end
      return r;
   endfunction

   // Lowest-index way whose valid bit is clear (only meaningful if one exists).
   function automatic logic [WAY_W-1:0] first_invalid(input logic [NUM_WAYS-1:0] v);
      logic [WAY_W-1:0]    r;
      logic [NUM_WAYS-1:0] shifted;
      r = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         shifted = v >> w;
         if (!shifted[0]) begin
            r = WAY_W'(w);
         end
      end
      return r;
   endfunction

   assign set_idx     = addr[OFF_W+SET_W-1:OFF_W];
   assign unused_addr = ^addr;
   assign cur_tree    = tree_q[set_idx];
   assign cur_valid   = valid_q[set_idx];

   assign idle          = (state == ST_IDLE);
   assign flush_accept  = idle && flush;
   assign do_replace    = idle && !flush && replace;
   assign do_access     = idle && !flush && !replace && access;
   assign do_invalidate = idle && !flush && !replace && !access && invalidate;

   // Victim selection: invalid ways take precedence over the tree.
   always_comb begin
      victim = '0;
      if (&cur_valid) begin
         victim = tree_victim(cur_tree);
      end else begin
         victim = first_invalid(cur_valid);
      end
   end

   assign preferred = busy ? '0 : victim;

   // Flush sequencer: one set is cleared per cycle until the last set is done.
   always_comb begin
      next_state   = state;
      next_counter = counter;
      case (state)
         ST_IDLE: begin
            if (flush) begin
               next_state   = ST_FLUSH;
               next_counter = '0;
            end
         end
         ST_FLUSH: begin
            if (counter == SET_W'(NUM_SETS - 1)) begin
               next_state   = ST_IDLE;
               next_counter = '0;
            end else begin
               next_counter = counter + SET_W'(1);
            end
         end
         default: begin
            next_state   = ST_IDLE;
            next_counter = '0;
         end
      endcase
   end

   // FSM state, set counter and the registered busy flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         counter <= '0;
         busy    <= 1'b0;
      end else begin
         state   <= next_state;
         counter <= next_counter;
         busy    <= (next_state == ST_FLUSH);
      end
   end

   // Per-set tree and valid storage; flush wins, then replace, access, invalidate.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            tree_q[SET_W'(s)]  <= '0;
            valid_q[SET_W'(s)] <= '0;
         end
      end else if (state == ST_FLUSH) begin
         tree_q[counter]  <= '0;
         valid_q[counter] <= '0;
      end else if (do_replace) begin
         valid_q[set_idx] <= cur_valid | (NUM_WAYS'(1) << victim);
         tree_q[set_idx]  <= tree_touch(cur_tree, victim);
      end else if (do_access) begin
         tree_q[set_idx]  <= tree_touch(cur_tree, hit_way);
      end else if (do_invalidate) begin
         valid_q[set_idx] <= cur_valid & ~(NUM_WAYS'(1) << inv_way);
      end
   end

`ifdef CRU_STATS_EN
   // Saturating statistics, cleared by reset and by an accepted flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_count     <= '0;
         replace_count <= '0;
      end else if (flush_accept) begin
         hit_count     <= '0;
         replace_count <= '0;
      end else begin
         if (do_access && (hit_count != 32'hFFFF_FFFF)) begin
            hit_count <= hit_count + 32'd1;
         end
         if (do_replace && (replace_count != 32'hFFFF_FFFF)) begin
            replace_count <= replace_count + 32'd1;
         end
      end
   end
`else
   logic unused_flush_accept;
   assign unused_flush_accept = flush_accept;
`endif

endmodule

// File: tb/tb_nway_plru_cru.sv
// tb_nway_plru_cru: scenario tasks plus randomized traffic checked against a
// behavioural PLRU model (4 ways, 16 sets, 32-byte blocks).
module tb_nway_plru_cru;

   localparam int NS = 16;
   localparam int NW = 4;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic        access;
   logic [1:0]  hit_way;
   logic        replace;
   logic        invalidate;
   logic [1:0]  inv_way;
   logic        flush;
   logic [1:0]  preferred;
   logic        busy;
`ifdef CRU_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] replace_count;
`endif

   int errors;
   int checks;

   // Reference model: tree bits in heap order, valid bits, flush countdown.
   int          m_tree  [NS][NW-1];
   int          m_valid [NS][NW];
   int          m_busy;
   int          m_ptr;
   int unsigned m_hits;
   int unsigned m_reps;

   nway_plru_cru #(
      .ADDR_SIZE (32),
      .NUM_SETS  (NS),
      .BLOCK_SIZE(32),
      .NUM_WAYS  (NW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .addr         (addr),
      .access       (access),
      .hit_way      (hit_way),
      .replace      (replace),
      .invalidate   (invalidate),
      .inv_way      (inv_way),
      .flush        (flush),
      .preferred    (preferred),
`ifdef CRU_STATS_EN
      .hit_count    (hit_count),
      .replace_count(replace_count),
`endif
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int set_of(input logic [31:0] a);
      return int'(a[6:3]);
   endfunction

   task automatic m_reset();
      for (int s = 0; s < NS; s++) begin
         for (int n = 0; n < NW - 1; n++) m_tree[s][n] = 0;
         for (int w = 0; w < NW; w++) m_valid[s][w] = 0;
      end
      m_busy = 0;
      m_ptr  = 0;
      m_hits = 0;
      m_reps = 0;
   endtask

   // Victim: lowest invalid way, otherwise descend the tree halving the range.
   function automatic int m_pref(input int s);
      int node, lo, size;
      for (int w = 0; w < NW; w++) if (m_valid[s][w] == 0) return w;
      node = 0; lo = 0; size = NW;
      while (size > 1) begin
         if (m_tree[s][node] != 0) begin
            lo   = lo + size / 2;
            node = 2 * node + 2;
         end else begin
            node = 2 * node + 1;
         end
         size = size / 2;
      end
      return lo;
   endfunction

   task automatic m_touch(input int s, input int w);
      int node, lo, size;
      node = 0; lo = 0; size = NW;
      while (size > 1) begin
         if (w < lo + size / 2) begin
            m_tree[s][node] = 1;
            node = 2 * node + 1;
         end else begin
            m_tree[s][node] = 0;
            lo   = lo + size / 2;
            node = 2 * node + 2;
         end
         size = size / 2;
      end
   endtask

   // One clock edge worth of model behaviour, using the current inputs.
   task automatic m_apply();
      int s, w;
      s = set_of(addr);
      if (m_busy > 0) begin
         for (int n = 0; n < NW - 1; n++) m_tree[m_ptr][n] = 0;
         for (int k = 0; k < NW; k++) m_valid[m_ptr][k] = 0;
         m_ptr++;
         m_busy--;
      end else if (flush) begin
         m_busy = NS;
         m_ptr  = 0;
         m_hits = 0;
         m_reps = 0;
      end else if (replace) begin
         w = m_pref(s);
         m_valid[s][w] = 1;
         m_touch(s, w);
         if (m_reps != 32'hFFFF_FFFF) m_reps++;
      end else if (access) begin
         m_touch(s, int'(hit_way));
         if (m_hits != 32'hFFFF_FFFF) m_hits++;
      end else if (invalidate) begin
         m_valid[s][int'(inv_way)] = 0;
      end
   endtask

   task automatic tick();
      if (rst) m_apply();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int s);
      logic [31:0] a;
      a      = $urandom;
      a[6:3] = s[3:0];
      addr   = a;
   endtask

   task automatic drive_idle();
      access     = 1'b0;
      replace    = 1'b0;
      invalidate = 1'b0;
      flush      = 1'b0;
      hit_way    = 2'd0;
      inv_way    = 2'd0;
   endtask

   task automatic test_reset();
      int sets [3] = '{3, 0, 15};
      rst = 1'b0;
      drive_idle();
      set_addr(0);
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      foreach (sets[i]) begin
         set_addr(sets[i]);
         #1;
         checks++;
         if (preferred !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_pref set %0d: got %0d expected 0", sets[i], preferred);
         end
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
         end
      end
      rst = 1'b1;
      set_addr(3);
      #1;
      checks++;
      if (preferred !== 2'd0) begin
         errors++;
         $display("[TB] FAIL post_reset_pref: got %0d expected 0", preferred);
      end
   endtask

   task automatic test_fill_and_hit();
      for (int i = 0; i < NW; i++) begin
         set_addr(5);
         #1;
         checks++;
         if (preferred !== 2'(i)) begin
            errors++;
            $display("[TB] FAIL fill_pref step %0d: got %0d expected %0d", i, preferred, i);
         end
         replace = 1'b1;
         tick();
         replace = 1'b0;
      end
      #1;
      checks++;
      if (preferred !== 2'd0) begin
         errors++;
         $display("[TB] FAIL full_tree_pref: got %0d expected 0", preferred);
      end
      access = 1'b1; hit_way = 2'd0;
      tick();
      access = 1'b0;
      #1;
      checks++;
      if (preferred !== 2'd2) begin
         errors++;
         $display("[TB] FAIL hit0_pref: got %0d expected 2", preferred);
      end
   endtask

   task automatic test_invalidate();
      set_addr(5);
      invalidate = 1'b1; inv_way = 2'd2;
      tick();
      invalidate = 1'b0;
      #1;
      checks++;
      if (preferred !== 2'd2) begin
         errors++;
         $display("[TB] FAIL inval_pref: got %0d expected 2", preferred);
      end
      access = 1'b1; hit_way = 2'd2;
      tick();
      access = 1'b0;
      #1;
      checks++;
      if (preferred !== 2'd2) begin
         errors++;
         $display("[TB] FAIL inval_hit_pref: got %0d expected 2", preferred);
      end
      replace = 1'b1;
      tick();
      replace = 1'b0;
      #1;
      checks++;
      if (preferred !== 2'd1) begin
         errors++;
         $display("[TB] FAIL refill_pref: got %0d expected 1", preferred);
      end
   endtask

   task automatic test_flush();
      int cnt;
      set_addr(7);
      replace = 1'b1;
      repeat (NW) tick();
      replace = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_busy_rise: got %b expected 1", busy);
      end
      cnt = 0;
      while (busy === 1'b1 && cnt < 40) begin
         replace = (cnt == 7);
         set_addr(7);
         tick();
         cnt++;
      end
      replace = 1'b0;
      checks++;
      if (cnt != NS) begin
         errors++;
         $display("[TB] FAIL flush_busy_len: got %0d cycles expected %0d", cnt, NS);
      end
      for (int s = 0; s < NS; s++) begin
         set_addr(s);
         #1;
         checks++;
         if (preferred !== 2'd0) begin
            errors++;
            $display("[TB] FAIL post_flush_pref set %0d: got %0d expected 0", s, preferred);
         end
      end
      set_addr(7);
      replace = 1'b1;
      tick();
      replace = 1'b0;
      #1;
      checks++;
      if (preferred !== 2'd1) begin
         errors++;
         $display("[TB] FAIL post_flush_invalid: got %0d expected 1", preferred);
      end
   endtask

   task automatic test_same_cycle();
      set_addr(9);
      replace = 1'b1; access = 1'b1; hit_way = 2'd3;
      tick();
      replace = 1'b0; access = 1'b0;
      #1;
      checks++;
      if (preferred !== 2'd1) begin
         errors++;
         $display("[TB] FAIL same_cycle_pref: got %0d expected 1", preferred);
      end
      invalidate = 1'b1; inv_way = 2'd0;
      #1;
      checks++;
      if (preferred !== 2'(m_pref(9))) begin
         errors++;
         $display("[TB] FAIL same_cycle_model: got %0d expected %0d", preferred, m_pref(9));
      end
      invalidate = 1'b0;
`ifdef CRU_STATS_EN
      checks++;
      if (replace_count !== m_reps) begin
         errors++;
         $display("[TB] FAIL same_cycle_reps: got %0d expected %0d", replace_count, m_reps);
      end
      checks++;
      if (hit_count !== m_hits) begin
         errors++;
         $display("[TB] FAIL same_cycle_hits: got %0d expected %0d", hit_count, m_hits);
      end
`endif
   endtask

   task automatic test_reset_mid_flush();
      set_addr(12);
      replace = 1'b1;
      tick();
      replace = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      repeat (5) tick();
      #3;
      rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset_busy: got %b expected 0", busy);
      end
      m_reset();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_addr(i * 6);
         #1;
         checks++;
         if (preferred !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_abort: got pref %0d busy %b expected 0 0", preferred, busy);
         end
         tick();
      end
   endtask

   task automatic test_random();
      int s;
      int exp;
      for (int i = 0; i < 600; i++) begin
         s = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NS - 1)) : int'($urandom_range(0, 3));
         set_addr(s);
         replace    = ($urandom_range(0, 3) == 0);
         access     = ($urandom_range(0, 2) == 0);
         hit_way    = 2'($urandom_range(0, 3));
         invalidate = ($urandom_range(0, 3) == 0);
         inv_way    = 2'($urandom_range(0, 3));
         flush      = ($urandom_range(0, 99) == 0);
         #1;
         exp = (m_busy > 0) ? 0 : m_pref(s);
         checks++;
         if (preferred !== 2'(exp) || busy !== (m_busy > 0)) begin
            errors++;
            $display("[TB] FAIL random_step %0d set %0d: got pref %0d busy %b expected %0d %0d",
                     i, s, preferred, busy, exp, (m_busy > 0));
         end
         tick();
`ifdef CRU_STATS_EN
         checks++;
         if (hit_count !== m_hits || replace_count !== m_reps) begin
            errors++;
            $display("[TB] FAIL random_stats %0d: got %0d/%0d expected %0d/%0d",
                     i, hit_count, replace_count, m_hits, m_reps);
         end
`endif
      end
      drive_idle();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b0;
      addr   = '0;
      drive_idle();
      test_reset();
      test_fill_and_hit();
      test_invalidate();
      test_flush();
      test_same_cycle();
      test_reset_mid_flush();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nway_plru_cru.md
Name: nway_plru_cru

Overview:
Parametrised N-way tree pseudo-LRU cache replacement unit. Successor to the two-way LRU bit unit.
- Tracks per-set PLRU tree state and per-way valid bits.
- Nominates the victim way, preferring invalid ways.
- Supports hit updates, invalidation and a multi-cycle set-walking flush.
- Sits beside the tag/data arrays of the set-associative data and instruction caches.

Parameters:
ADDR_SIZE, 32, address width in bits
NUM_SETS, 16, number of sets; power of 2, >=2
BLOCK_SIZE, 32, block size; offset width OffW = $clog2(BLOCK_SIZE/4)
NUM_WAYS, 4, associativity; power of 2, >=2; WayW = $clog2(NUM_WAYS)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low)
addr  input  ADDR_SIZE  access address; set = addr[OffW+SetW-1:OffW], SetW = $clog2(NUM_SETS)
access  input  1  hit update request for hit_way in addressed set
hit_way  input  WayW  way that hit
replace  input  1  fill: victim = preferred is filled this cycle
invalidate  input  1  clear valid bit of inv_way in addressed set
inv_way  input  WayW  way to invalidate
flush  input  1  pulse: clear all sets
preferred  output  WayW  victim way for addressed set (combinational)
busy  output  1  flush in progress; all requests ignored

Behaviour:
- State per set: NUM_WAYS-1 tree bits (heap order: node 0 is the root; children of node i are 2i+1 and 2i+2) plus NUM_WAYS valid bits.
- Tree convention: bit=0 means the victim is in the lower-index half; bit=1 means the upper half.
- preferred, combinational from the addressed set:
  - If any valid bit is 0: lowest-index invalid way.
  - Else: walk the tree from the root to a leaf.
  - Forced to 0 while busy.
- Touch(w): every node on w's path is set to point away from w (w in lower half -> 1, upper half -> 0). Nodes off the path are unchanged.
- Per cycle, at most one operation applies to state. Priority: flush > replace > access > invalidate. Lower-priority requests in the same cycle are dropped, not queued.
- replace: valid[set][preferred] <= 1, then Touch(preferred). Both take effect at the next edge.
- access: Touch(hit_way). Valid bits unchanged. An access to an invalid way still updates the tree.
- invalidate: valid[set][inv_way] <= 0. Tree unchanged.
- FSM states:
  - IDLE -> FLUSH on flush=1 with busy=0. The set counter is loaded with 0.
  - In FLUSH, each cycle clears the tree and valid bits of set[counter], then increments the counter.
  - After set NUM_SETS-1 is cleared, return to IDLE.
  - busy is registered: high exactly NUM_SETS cycles, starting the cycle after flush is sampled.
  - flush while busy is ignored (no restart). access/replace/invalidate while busy are ignored.
- Reset (rst=0, asynchronous): all tree bits 0, all valid bits 0, FSM IDLE, counter 0, busy=0. Hence preferred=0 for every set. Reset mid-flush aborts immediately.
- Single-cycle latency: an update at edge k is visible on preferred after edge k.

Optional Feature:
CRU_STATS_EN:
- Defined: adds outputs hit_count[31:0] and replace_count[31:0].
  - hit_count increments on each applied access; replace_count on each applied replace.
  - Both saturate at 0xFFFFFFFF.
  - Both clear on reset and in the cycle a flush is accepted.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
All scenarios use NUM_WAYS=4 and NUM_SETS=16.
- Reset, then addr selects set 3 -> preferred=0, busy=0. Repeat for sets 0 and 15 -> preferred=0.
- Four replaces to set 5 -> preferred before each is 0,1,2,3. Tree after the fourth is 000 -> preferred=0. Then access hit_way=0 -> tree 110 -> preferred=2.
- Set 5 full, then invalidate inv_way=2 and access hit_way=2 -> preferred stays 2 (invalid way wins over tree). Replace -> valid restored; tree points away from way 2.
- Fill set 7, then pulse flush -> busy high 16 cycles. A replace issued mid-flush is ignored. After busy falls, preferred=0 for every set and all ways are invalid.
- replace and access (hit_way=3) same cycle on fresh set 9 -> only the replace applies: way 0 valid, tree 110, preferred=1 next. With CRU_STATS_EN: replace_count=1, hit_count=0.
- Assert rst=0 asynchronously in flush cycle 6 -> busy=0 before the next edge. After release, preferred=0 and no residual flush.
